// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: control/preload inputs and the instruction valid/ready stream.
// The fetch unit sits on the slave side; the sequencer/consumer drives the master side.
interface instruction_fetch_unit_if #(
  parameter int AW = 6
);
  logic          start;
  logic          ready;
  logic          redirect_en;
  logic [31:0]   redirect_target;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic [31:0]   Instruction_Code;
  logic [31:0]   instr_pc;
  logic          instr_valid;
  logic [31:0]   PC;
  logic          busy;
  logic          halted;

  modport slave (
    input  start, ready, redirect_en, redirect_target, prog_we, prog_addr, prog_data,
    output Instruction_Code, instr_pc, instr_valid, PC, busy, halted
  );

  modport master (
    output start, ready, redirect_en, redirect_target, prog_we, prog_addr, prog_data,
    input  Instruction_Code, instr_pc, instr_valid, PC, busy, halted
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: PC, word-addressed instruction memory, and a
// single registered output slot handed downstream over valid/ready.
module instruction_fetch_unit #(
  parameter int          DEPTH     = 64,
  parameter int          AW        = 6,
  parameter logic [31:0] HALT_WORD = 32'h0000_003F
) (
  input logic                   clk,
  input logic                   reset,
  instruction_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t        state_q, state_n;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   pc_q, pc_n;
  logic [31:0]   code_q, code_n;
  logic [31:0]   ipc_q, ipc_n;
  logic          vld_q, vld_n;
  logic          busy_q, halted_q;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic          advance;
  logic          unused_tgt;

  assign idx        = pc_q[AW+1:2];
  assign rd_word    = mem[idx];
  assign advance    = !vld_q || bus.ready;
  assign unused_tgt = ^bus.redirect_target[1:0];

  // Program memory is not reset; preload is only accepted while idle.
  always_ff @(posedge clk) begin
    if (reset && state_q == S_IDLE && bus.prog_we)
      mem[bus.prog_addr] <= bus.prog_data;
  end

  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    code_n  = code_q;
    ipc_n   = ipc_q;
    vld_n   = vld_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_n = S_RUN;
      end
      S_RUN: begin
        if (bus.redirect_en) begin
          pc_n  = {bus.redirect_target[31:2], 2'b00};
          vld_n = 1'b0;
        end else if (advance) begin
          if (rd_word == HALT_WORD) begin
            // HALT word is consumed by the fetcher, never issued; PC parks on it.
            state_n = S_HALT;
            vld_n   = 1'b0;
          end else begin
            code_n = rd_word;
            ipc_n  = pc_q;
            vld_n  = 1'b1;
            pc_n   = pc_q + 32'd4;
          end
        end
      end
      S_HALT: ;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      code_q   <= '0;
      ipc_q    <= '0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      pc_q     <= pc_n;
      code_q   <= code_n;
      ipc_q    <= ipc_n;
      vld_q    <= vld_n;
      busy_q   <= (state_n == S_RUN);
      halted_q <= (state_n == S_HALT);
    end
  end

  assign bus.Instruction_Code = code_q;
  assign bus.instr_pc         = ipc_q;
  assign bus.instr_valid      = vld_q;
  assign bus.PC               = pc_q;
  assign bus.busy             = busy_q;
  assign bus.halted           = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: fixed vector table, corner sequences, and
// randomized traffic compared against a spec-level behavioural model.
module tb_instruction_fetch_unit;
  localparam int          DEPTH = 64;
  localparam int          AW    = 6;
  localparam logic [31:0] HALT  = 32'h0000_003F;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.AW(AW)) ifc ();
  instruction_fetch_unit #(.DEPTH(DEPTH), .AW(AW), .HALT_WORD(HALT)) dut (
    .clk(clk), .reset(reset), .bus(ifc)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: 0=idle 1=run 2=halt
  logic [31:0] m_mem [DEPTH];
  int          m_state;
  logic [31:0] m_pc, m_code, m_ipc;
  logic        m_vld;

  typedef struct {
    logic        rst, start, ready, redir;
    logic [31:0] tgt, code, ipc, pc;
    logic        vld, busy, halted;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic start, logic ready, logic redir, logic [31:0] tgt,
                              logic [31:0] code, logic [31:0] ipc, logic [31:0] pc,
                              logic vld, logic busy, logic halted);
    vec_t v;
    v.rst = rst; v.start = start; v.ready = ready; v.redir = redir; v.tgt = tgt;
    v.code = code; v.ipc = ipc; v.pc = pc; v.vld = vld; v.busy = busy; v.halted = halted;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = '0; m_code = '0; m_ipc = '0; m_vld = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] w;
    if (m_state == 0) begin
      if (ifc.prog_we) m_mem[ifc.prog_addr] = ifc.prog_data;
      if (ifc.start) m_state = 1;
    end else if (m_state == 1) begin
      if (ifc.redirect_en) begin
        m_pc  = ifc.redirect_target & ~32'd3;
        m_vld = 1'b0;
      end else if (!m_vld || ifc.ready) begin
        w = m_mem[(m_pc >> 2) % DEPTH];
        if (w == HALT) begin
          m_state = 2;
          m_vld   = 1'b0;
        end else begin
          m_code = w; m_ipc = m_pc; m_vld = 1'b1; m_pc = m_pc + 4;
        end
      end
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, ".code"},   ifc.Instruction_Code, m_code);
    chk({tag, ".ipc"},    ifc.instr_pc, m_ipc);
    chk({tag, ".valid"},  {31'd0, ifc.instr_valid}, {31'd0, m_vld});
    chk({tag, ".pc"},     ifc.PC, m_pc);
    chk({tag, ".busy"},   {31'd0, ifc.busy}, {31'd0, m_state == 1});
    chk({tag, ".halted"}, {31'd0, ifc.halted}, {31'd0, m_state == 2});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    ifc.start = 0; ifc.ready = 0; ifc.redirect_en = 0; ifc.redirect_target = '0;
    ifc.prog_we = 0; ifc.prog_addr = '0; ifc.prog_data = '0;
  endtask

  // Called just after a rising edge; releases on the falling edge to stay clear of it.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic prog(int a, logic [31:0] d);
    ifc.prog_we = 1; ifc.prog_addr = AW'(a); ifc.prog_data = d;
    tick();
    ifc.prog_we = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    model_reset();
    #12;
    check_model("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) prog(i, 32'h1000_0000 + 32'(i * 4));
    prog(0, 32'h0022_1820); prog(1, 32'h0022_1822); prog(2, 32'h0022_1824); prog(3, HALT);
    prog(8, 32'hA5A5_0008);

    // straight-line run to HALT
    tbl.push_back(mk(1,1,1,0,0, 32'h0,        0,     0, 0,1,0));
    tbl.push_back(mk(0,0,1,0,0, 32'h00221820, 0,     4, 1,1,0));
    tbl.push_back(mk(0,0,1,0,0, 32'h00221822, 4,     8, 1,1,0));
    tbl.push_back(mk(0,0,1,0,0, 32'h00221824, 8,    12, 1,1,0));
    tbl.push_back(mk(0,0,1,0,0, 32'h00221824, 8,    12, 0,0,1));
    tbl.push_back(mk(0,1,1,1,4, 32'h00221824, 8,    12, 0,0,1));
    // downstream stall for three cycles
    tbl.push_back(mk(1,1,0,0,0, 32'h0,        0,     0, 0,1,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h00221820, 0,     4, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h00221820, 0,     4, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h00221820, 0,     4, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h00221820, 0,     4, 1,1,0));
    tbl.push_back(mk(0,0,1,0,0, 32'h00221822, 4,     8, 1,1,0));
    tbl.push_back(mk(0,0,1,0,0, 32'h00221824, 8,    12, 1,1,0));
    tbl.push_back(mk(0,0,1,0,0, 32'h00221824, 8,    12, 0,0,1));
    // redirect at PC=8, stalled redirect with alias, PC wrap
    tbl.push_back(mk(1,1,1,0,0, 32'h0,        0,     0, 0,1,0));
    tbl.push_back(mk(0,0,1,0,0, 32'h00221820, 0,     4, 1,1,0));
    tbl.push_back(mk(0,0,1,0,0, 32'h00221822, 4,     8, 1,1,0));
    tbl.push_back(mk(0,0,1,1,32'h22, 32'h00221822, 4, 32'h20, 0,1,0));
    tbl.push_back(mk(0,0,0,0,0, 32'hA5A50008, 32'h20, 32'h24, 1,1,0));
    tbl.push_back(mk(0,0,0,1,32'h100, 32'hA5A50008, 32'h20, 32'h100, 0,1,0));
    tbl.push_back(mk(0,0,1,0,0, 32'h00221820, 32'h100, 32'h104, 1,1,0));
    tbl.push_back(mk(0,0,1,1,32'hFFFF_FFFF, 32'h00221820, 32'h100, 32'hFFFF_FFFC, 0,1,0));
    tbl.push_back(mk(0,0,1,0,0, 32'h1000_00FC, 32'hFFFF_FFFC, 32'h0, 1,1,0));
    tbl.push_back(mk(0,0,1,0,0, 32'h00221820, 32'h0, 32'h4, 1,1,0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      ifc.start = tbl[i].start; ifc.ready = tbl[i].ready;
      ifc.redirect_en = tbl[i].redir; ifc.redirect_target = tbl[i].tgt;
      tick();
      chk($sformatf("vec%0d.code", i), ifc.Instruction_Code, tbl[i].code);
      chk($sformatf("vec%0d.ipc", i), ifc.instr_pc, tbl[i].ipc);
      chk($sformatf("vec%0d.pc", i), ifc.PC, tbl[i].pc);
      chk($sformatf("vec%0d.vbh", i), {29'd0, ifc.instr_valid, ifc.busy, ifc.halted},
          {29'd0, tbl[i].vld, tbl[i].busy, tbl[i].halted});
    end
    clear_inputs();

    // Asynchronous reset with an instruction held, then re-run from 0
    do_reset();
    ifc.start = 1; ifc.ready = 1; tick(); ifc.start = 0;
    tick();
    ifc.ready = 0; tick();
    check_model("held");
    reset = 1'b0;
    #1;
    chk("async_rst.code", ifc.Instruction_Code, 32'h0);
    chk("async_rst.vbh", {29'd0, ifc.instr_valid, ifc.busy, ifc.halted}, 32'h0);
    chk("async_rst.pc", ifc.PC, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    ifc.start = 1; ifc.ready = 1; tick(); ifc.start = 0;
    tick();
    chk("rerun.code", ifc.Instruction_Code, 32'h0022_1820);

    // Write ignored in RUN; write together with start honoured in IDLE
    ifc.prog_we = 1; ifc.prog_addr = 1; ifc.prog_data = 32'hDEAD_BEEF;
    ifc.redirect_en = 1; ifc.redirect_target = 32'h4; tick();
    ifc.prog_we = 0; ifc.redirect_en = 0; tick();
    chk("run_we_ignored", ifc.Instruction_Code, 32'h0022_1822);
    check_model("run_we");
    do_reset();
    ifc.prog_we = 1; ifc.prog_addr = 5; ifc.prog_data = 32'h1111_0005; ifc.start = 1; tick();
    ifc.prog_we = 0; ifc.start = 0;
    chk("we_start.busy", {31'd0, ifc.busy}, 32'd1);
    ifc.redirect_en = 1; ifc.redirect_target = 32'h14; tick();
    ifc.redirect_en = 0; tick();
    chk("we_start.code", ifc.Instruction_Code, 32'h1111_0005);
    check_model("we_start");

    // Randomized traffic against the model
    clear_inputs();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (m_state == 2 || $urandom_range(0, 199) == 0) begin
        clear_inputs();
        do_reset();
      end
      ifc.prog_we = (m_state == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0);
      ifc.prog_addr = AW'($urandom_range(0, DEPTH - 1));
      ifc.prog_data = ($urandom_range(0, 31) == 0) ? HALT : $urandom;
      ifc.start = ($urandom_range(0, 9) == 0);
      ifc.ready = ($urandom_range(0, 3) != 0);
      ifc.redirect_en = ($urandom_range(0, 9) == 0);
      ifc.redirect_target = $urandom;
      tick();
      check_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front end of the single-cycle datapath. Holds the program counter and a word-addressed instruction memory.
- Presents one registered 32-bit Instruction_Code per cycle to Control_Unit and the register-file read stage through a valid/ready handshake.
- Supports memory preload while idle, taken-branch/jump redirect, downstream stall, and stop on a HALT word.

Parameters:
DEPTH, 64, number of 32-bit instruction words in memory
AW, 6, memory index width; log2(DEPTH)
HALT_WORD, 32'h0000003F, encoding that stops fetch (R-type opcode 000000, unused funct 111111)

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins fetch from IDLE
ready  input  1  downstream accepts the current instruction this cycle
redirect_en  input  1  branch/jump taken; load redirect_target into PC
redirect_target  input  32  new byte address; bits [1:0] ignored
prog_we  input  1  memory write strobe; honoured in IDLE only
prog_addr  input  AW  word index for prog_we
prog_data  input  32  word written on prog_we
Instruction_Code  output  32  fetched instruction, registered
instr_pc  output  32  byte address of Instruction_Code
instr_valid  output  1  Instruction_Code/instr_pc hold a valid instruction
PC  output  32  address of the next word to fetch
busy  output  1  high in RUN
halted  output  1  high in HALT

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, PC=0, Instruction_Code=0, instr_pc=0, instr_valid=0, busy=0, halted=0. Memory contents are not cleared. Reset asserted mid-RUN aborts immediately; any held instruction is dropped.
- States: IDLE, RUN, HALT. busy=(state==RUN); halted=(state==HALT); both registered with state.
- IDLE:
  - prog_we=1 writes mem[prog_addr]=prog_data on the clock edge.
  - start=1 moves to RUN. The first fetch happens in the first RUN cycle, not in the start cycle.
  - prog_we and start together: the write completes and the state changes.
- RUN, "advance" = (!instr_valid || ready). Priority, highest first:
  1. redirect_en=1: PC <= {redirect_target[31:2],2'b00}; instr_valid <= 0 (flush); ready ignored; no fetch this cycle.
  2. advance and mem[PC[AW+1:2]]==HALT_WORD: state <= HALT; instr_valid <= 0; PC holds at the HALT word address. The HALT word is never issued.
  3. advance: Instruction_Code <= mem[PC[AW+1:2]]; instr_pc <= PC; instr_valid <= 1; PC <= PC+4.
  4. Otherwise (instr_valid && !ready, stall): all outputs and PC hold.
- Latency: an instruction at PC appears on Instruction_Code one clock after the fetching edge. With ready=1 continuously, throughput is one instruction per cycle.
- Handshake: the consumer takes the instruction on any edge where instr_valid && ready. Instruction_Code is stable while instr_valid && !ready.
- Memory index uses PC[AW+1:2] only, so addresses ≥ DEPTH*4 alias modulo DEPTH. PC itself is 32-bit and wraps 0xFFFFFFFC -> 0x00000000.
- In RUN and HALT, prog_we is ignored and start has no effect.
- HALT: outputs hold, instr_valid=0. Exit is by reset only.
- redirect_en outside RUN is ignored.

Test Plan:
- Preload mem[0..3]=32'h00221820, 32'h00221822, 32'h00221824, HALT_WORD; pulse start; ready=1 -> Instruction_Code 00221820/00221822/00221824 on three consecutive cycles, instr_pc 0/4/8, then halted=1, instr_valid=0, PC=12.
- Same program, ready=0 for 3 cycles after the first word is valid -> Instruction_Code=00221820 and PC=4 held for those 3 cycles; next word follows one cycle after ready rises.
- In RUN at PC=8, redirect_en=1, target=32'h00000022 -> next cycle PC=0x20, instr_valid=0; following cycle instr_pc=0x20 with Instruction_Code=mem[8].
- redirect_en and ready=0 in the same cycle while stalled -> flush happens anyway; instr_valid=0 next cycle.
- Assert reset=0 mid-RUN with a valid instruction held -> all outputs 0 and state IDLE immediately, before the next clock edge. Memory still holds its program; start re-runs it from 0.
- prog_we during RUN to index 1 -> mem[1] unchanged. Redirect to 32'h00000100 with DEPTH=64 -> fetches mem[0] (alias), instr_pc=0x100.
